// File: rtl/term_stim_pkg.sv
// Shared widths, types and the round-robin search used by the terminal stimulus mux.
package term_stim_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 8;
    localparam int DROP_W_DEF = 8;
    localparam int CHAN_W     = (NUM_CH_DEF > 1) ? $clog2(NUM_CH_DEF) : 1;

    typedef logic [CHAN_W-1:0]     chan_t;
    typedef logic [DATA_W_DEF-1:0] data_t;

    // Returns {found, index} of the first set mask bit after ptr, wrapping modulo n (n <= 16).
    function automatic logic [4:0] rr_next(input logic [3:0] ptr, input logic [15:0] mask, input int n);
        logic [4:0] res;
        int         idx;
        logic [3:0] idx4;
        res = '0;
        // Walk from the farthest candidate back so the nearest one is kept last.
        for (int i = 16; i >= 1; i--) begin
            if (i <= n) begin
                idx  = (int'(ptr) + i) % n;
                idx4 = 4'(idx);
                if (mask[idx4]) begin
                    res = {1'b1, idx4};
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/term_stim_mux_if.sv
// Stimulus, output stream and status signals of term_stim_mux bundled as one interface.
interface term_stim_mux_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int DROP_W = 8
) ();
    localparam int CHAN_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]        stim_req;
    logic [NUM_CH*DATA_W-1:0] stim_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic [CHAN_BITS-1:0]     out_chan;
    logic [NUM_CH-1:0]        ch_full;
    logic [NUM_CH-1:0]        ch_ovf;
    logic [NUM_CH-1:0]        ovf_clr;
    logic [NUM_CH*DROP_W-1:0] drop_cnt;

    // master is the mux itself: it sources the merged stream and the status.
    modport master (
        input  stim_req, stim_data, out_ready, ovf_clr,
        output out_valid, out_data, out_chan, ch_full, ch_ovf, drop_cnt
    );

    modport slave (
        output stim_req, stim_data, out_ready, ovf_clr,
        input  out_valid, out_data, out_chan, ch_full, ch_ovf, drop_cnt
    );
endinterface

// File: rtl/term_stim_fifo.sv
// Per-channel synchronous FIFO; a push into a full FIFO is accepted when a pop happens on the same edge.
module term_stim_fifo
    import term_stim_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              push_ok;
    logic              pop_ok;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/term_stim_mux.sv
// Merges NUM_CH buffered stimulus byte streams round-robin onto one tagged valid/ready stream,
// keeping a sticky overflow flag and a saturating drop counter per channel.
module term_stim_mux
    import term_stim_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DROP_W = DROP_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    term_stim_mux_if.master bus
);
    localparam int CHAN_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]    req_v;
    logic [NUM_CH-1:0]    fifo_full;
    logic [NUM_CH-1:0]    fifo_empty;
    logic [NUM_CH-1:0]    pop_vec;
    logic [NUM_CH-1:0]    drop_v;
    logic [DATA_W-1:0]    fifo_rd [NUM_CH];

    logic [4:0]           grant;
    logic [CHAN_BITS-1:0] grant_idx;
    logic                 load;

    logic                 out_valid_q, out_valid_d;
    logic [DATA_W-1:0]    out_data_q,  out_data_d;
    logic [CHAN_BITS-1:0] out_chan_q,  out_chan_d;
    logic [CHAN_BITS-1:0] rr_q,        rr_d;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic              ovf_q;
            logic [DROP_W-1:0] drop_q;

            // X/Z on a request line must never write, so only a definite 1 is a request.
            assign req_v[gi]  = (bus.stim_req[gi] === 1'b1);
            assign drop_v[gi] = req_v[gi] && fifo_full[gi] && !pop_vec[gi];

            term_stim_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH)
            ) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .push    (req_v[gi]),
                .wr_data (bus.stim_data[gi*DATA_W +: DATA_W]),
                .pop     (pop_vec[gi]),
                .rd_data (fifo_rd[gi]),
                .full    (fifo_full[gi]),
                .empty   (fifo_empty[gi])
            );

            always_ff @(posedge clk) begin
                if (rst || bus.ovf_clr[gi]) begin
                    ovf_q  <= 1'b0;
                    drop_q <= '0;
                end else if (drop_v[gi]) begin
                    ovf_q <= 1'b1;
                    if (drop_q != '1) begin
                        drop_q <= drop_q + 1'b1;
                    end
                end
            end

            assign bus.ch_full[gi]                      = fifo_full[gi];
            assign bus.ch_ovf[gi]                       = ovf_q;
            assign bus.drop_cnt[gi*DROP_W +: DROP_W]    = drop_q;
        end
    endgenerate

    // Grant uses the FIFO state from before this edge; the granted FIFO pops as the output loads.
    always_comb begin
        grant       = rr_next(4'(rr_q), 16'(~fifo_empty), NUM_CH);
        grant_idx   = CHAN_BITS'(grant[3:0]);
        load        = (!out_valid_q || bus.out_ready) && grant[4];
        pop_vec     = '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        rr_d        = rr_q;
        if (load) begin
            pop_vec[grant_idx] = 1'b1;
            out_valid_d        = 1'b1;
            out_data_d         = fifo_rd[grant_idx];
            out_chan_d         = grant_idx;
            rr_d               = grant_idx;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            rr_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            rr_q        <= rr_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;

endmodule

// File: tb/tb_term_stim_mux.sv
// Directed bench for term_stim_mux: latency, backpressure, overflow, fairness, full+pop, reset.
module tb_term_stim_mux;
    import term_stim_pkg::*;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int DEP = 8;
    localparam int DRW = 8;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    term_stim_mux_if #(.NUM_CH(NCH), .DATA_W(DW), .DROP_W(DRW)) bus ();

    term_stim_mux #(
        .NUM_CH (NCH),
        .DATA_W (DW),
        .DEPTH  (DEP),
        .DROP_W (DRW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int c, input logic [7:0] d);
        bus.stim_req[c]            = 1'b1;
        bus.stim_data[c*DW +: DW]  = d;
    endtask

    initial begin
        rst           = 1'b1;
        bus.stim_req  = '0;
        bus.stim_data = '0;
        bus.out_ready = 1'b0;
        bus.ovf_clr   = '0;
        tick();
        tick();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data",  32'(bus.out_data),  32'd0);
        chk("rst_chan",  32'(bus.out_chan),  32'd0);
        chk("rst_full",  32'(bus.ch_full),   32'd0);
        chk("rst_ovf",   32'(bus.ch_ovf),    32'd0);
        chk("rst_drop",  bus.drop_cnt,       32'd0);
        rst = 1'b0;

        // 1: single byte latency
        bus.out_ready = 1'b1;
        set_req(0, 8'h41);
        tick();
        bus.stim_req = '0;
        chk("t1_valid_n", 32'(bus.out_valid), 32'd0);
        tick();
        chk("t1_valid_n1", 32'(bus.out_valid), 32'd1);
        chk("t1_data",     32'(bus.out_data),  32'h41);
        chk("t1_chan",     32'(bus.out_chan),  32'd0);
        tick();
        chk("t1_valid_n2", 32'(bus.out_valid), 32'd0);

        // 2: backpressure hold
        bus.out_ready = 1'b0;
        set_req(1, 8'h10);
        tick();
        set_req(1, 8'h11);
        tick();
        bus.stim_req = '0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("t2_hold_data",  32'(bus.out_data),  32'h10);
            chk("t2_hold_chan",  32'(bus.out_chan),  32'd1);
            tick();
        end
        bus.out_ready = 1'b1;
        chk("t2_first", 32'(bus.out_data), 32'h10);
        tick();
        chk("t2_second_valid", 32'(bus.out_valid), 32'd1);
        chk("t2_second_data",  32'(bus.out_data),  32'h11);
        chk("t2_second_chan",  32'(bus.out_chan),  32'd1);
        tick();
        chk("t2_idle", 32'(bus.out_valid), 32'd0);

        // 3: overflow on ch2 while the output register is held by a ch3 byte
        bus.out_ready = 1'b0;
        set_req(3, 8'h99);
        tick();
        bus.stim_req = '0;
        tick();
        chk("t3_blocker", 32'(bus.out_data), 32'h99);
        for (int i = 0; i < DEP + 3; i++) begin
            set_req(2, 8'(8'h20 + i));
            tick();
        end
        bus.stim_req = '0;
        chk("t3_full", 32'(bus.ch_full),  32'b0100);
        chk("t3_ovf",  32'(bus.ch_ovf),   32'b0100);
        chk("t3_drop", bus.drop_cnt,      32'h0003_0000);
        bus.ovf_clr[2] = 1'b1;
        tick();
        bus.ovf_clr = '0;
        chk("t3_clr_ovf",  32'(bus.ch_ovf), 32'd0);
        chk("t3_clr_drop", bus.drop_cnt,    32'd0);
        chk("t3_clr_full", 32'(bus.ch_full), 32'b0100);
        bus.out_ready = 1'b1;
        chk("t3_drain_blk_chan", 32'(bus.out_chan), 32'd3);
        tick();
        for (int i = 0; i < DEP; i++) begin
            chk("t3_drain_valid", 32'(bus.out_valid), 32'd1);
            chk("t3_drain_data",  32'(bus.out_data),  32'(8'h20 + i));
            chk("t3_drain_chan",  32'(bus.out_chan),  32'd2);
            tick();
        end
        chk("t3_drained", 32'(bus.out_valid), 32'd0);
        chk("t3_not_full", 32'(bus.ch_full), 32'd0);

        // 4: fairness after reset (rr pointer back at 0)
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < NCH; c++) set_req(c, 8'(c * 16 + k));
            tick();
        end
        bus.stim_req  = '0;
        bus.out_ready = 1'b1;
        for (int p = 0; p < 12; p++) begin
            chk("t4_valid", 32'(bus.out_valid), 32'd1);
            chk("t4_chan",  32'(bus.out_chan),  32'((p + 1) % NCH));
            chk("t4_data",  32'(bus.out_data),  32'(((p + 1) % NCH) * 16 + p / 4));
            tick();
        end
        chk("t4_idle", 32'(bus.out_valid), 32'd0);

        // 5: push into a full FIFO on the edge it pops
        bus.out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            set_req(0, 8'(8'h60 + i));
            tick();
        end
        bus.stim_req = '0;
        chk("t5_full",    32'(bus.ch_full), 32'b0001);
        chk("t5_drop0",   bus.drop_cnt,     32'd0);
        bus.out_ready = 1'b1;
        set_req(0, 8'h55);
        tick();
        bus.stim_req = '0;
        chk("t5_nodrop",  bus.drop_cnt,      32'd0);
        chk("t5_noovf",   32'(bus.ch_ovf),   32'd0);
        chk("t5_full2",   32'(bus.ch_full),  32'b0001);
        chk("t5_data61",  32'(bus.out_data), 32'h61);
        for (int i = 2; i <= 8; i++) begin
            tick();
            chk("t5_drain", 32'(bus.out_data), 32'(8'h60 + i));
        end
        tick();
        chk("t5_last_data", 32'(bus.out_data), 32'h55);
        chk("t5_last_chan", 32'(bus.out_chan), 32'd0);
        tick();
        chk("t5_idle", 32'(bus.out_valid), 32'd0);

        // 5b: drop counter saturation and clear-beats-drop
        bus.out_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            set_req(0, 8'hAA);
            tick();
        end
        chk("t5_sat",     bus.drop_cnt,     32'h0000_00FF);
        chk("t5_sat_ovf", 32'(bus.ch_ovf),  32'b0001);
        bus.ovf_clr[0] = 1'b1;
        tick();
        bus.ovf_clr = '0;
        chk("t5_clrwin_drop", bus.drop_cnt,    32'd0);
        chk("t5_clrwin_ovf",  32'(bus.ch_ovf), 32'd0);
        tick();
        chk("t5_after_drop", bus.drop_cnt,    32'd1);
        chk("t5_after_ovf",  32'(bus.ch_ovf), 32'b0001);
        bus.stim_req = '0;

        // 6: reset mid-stream
        for (int k = 0; k < 4; k++) begin
            for (int c = 1; c < NCH; c++) set_req(c, 8'(8'hB0 + c * 4 + k));
            tick();
        end
        bus.stim_req = '0;
        chk("t6_pre_valid", 32'(bus.out_valid), 32'd1);
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        chk("t6_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_data",  32'(bus.out_data),  32'd0);
        chk("t6_chan",  32'(bus.out_chan),  32'd0);
        chk("t6_full",  32'(bus.ch_full),   32'd0);
        chk("t6_ovf",   32'(bus.ch_ovf),    32'd0);
        chk("t6_drop",  bus.drop_cnt,       32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_stale", 32'(bus.out_valid), 32'd0);
        end
        set_req(3, 8'h77);
        tick();
        bus.stim_req = '0;
        chk("t6_fresh_lat", 32'(bus.out_valid), 32'd0);
        tick();
        chk("t6_fresh_valid", 32'(bus.out_valid), 32'd1);
        chk("t6_fresh_data",  32'(bus.out_data),  32'h77);
        chk("t6_fresh_chan",  32'(bus.out_chan),  32'd3);
        tick();
        chk("t6_fresh_idle", 32'(bus.out_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
